// File: rtl/md_sched_pkg.sv
// md_sched_pkg
// Shared definitions for the multiply/divide unit and its issue scheduler.
//   - MD_* operation codes driven by the instruction decoder on md_op
//   - default busy-cycle counts for multiply and divide
//   - scheduler state enum and a small classification helper
package md_sched_pkg;

   // Operation codes carried on md_op from the E stage
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   // Default number of cycles the unit stays busy for each long operation
   localparam int MD_MULT_CYC = 5;
   localparam int MD_DIV_CYC  = 10;

   // Width of the busy countdown; comfortably holds either cycle count
   localparam int MD_CNT_W = 16;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } mdState_e;

   // True for the operations that occupy the unit for several cycles
   function automatic logic isLongOp(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sched.sv
// md_sched
// Multiply/divide unit with its own issue scheduler. An MDU op arriving from
// the E stage either writes HI/LO directly (mthi/mtlo) or starts a long
// mult/div whose result is computed up front, parked in a pending register
// and committed to HI/LO when the busy countdown expires. The stall request
// keeps any MDU instruction in D until the unit is free again.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   start     in   E-stage instruction is a qualified MDU op
//   md_op     in   [2:0] operation code (MD_* in md_sched_pkg)
//   A         in   [31:0] rs operand (forwarded)
//   B         in   [31:0] rt operand (forwarded)
//   md_use_D  in   D-stage instruction touches the MDU
//   HI        out  [31:0] HI register
//   LO        out  [31:0] LO register
//   busy      out  long operation in progress
//   stall_md  out  stall request to the D stage
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_CYC = MD_MULT_CYC,
   parameter int DIV_CYC  = MD_DIV_CYC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        md_use_D,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        stall_md
);

   mdState_e              state_q, state_d;
   logic [MD_CNT_W-1:0]   count_q, count_d;
   logic [63:0]           pend_q, pend_d;
   logic                  pendValid_q, pendValid_d;
   logic [31:0]           hi_q, hi_d;
   logic [31:0]           lo_q, lo_d;

   logic                  isDivOp;
   logic                  divByZero;
   logic [63:0]           mulSigned, mulUnsigned;
   logic [31:0]           divisor, magA, magB, magQuot, magRem;
   logic [31:0]           sQuot, sRem, uQuot, uRem;
   logic [63:0]           longResult;

   // Result datapath, evaluated combinationally from the E-stage operands.
   // A zero divisor is replaced by 1 so the divider never sees x/0; that
   // result is discarded at commit anyway. Signed division is done on
   // magnitudes and then re-signed, which gives truncation toward zero and a
   // remainder carrying the dividend's sign without relying on the
   // simulator's handling of the most-negative / -1 overflow case.
   always_comb begin
      isDivOp     = (md_op == MD_DIV) || (md_op == MD_DIVU);
      divByZero   = (B == 32'd0);
      mulSigned   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      mulUnsigned = {32'd0, A} * {32'd0, B};
      divisor     = divByZero ? 32'd1 : B;
      uQuot       = A / divisor;
      uRem        = A % divisor;
      magA        = A[31] ? (~A + 32'd1) : A;
      magB        = divisor[31] ? (~divisor + 32'd1) : divisor;
      magQuot     = magA / magB;
      magRem      = magA % magB;
      sQuot       = (A[31] ^ divisor[31]) ? (~magQuot + 32'd1) : magQuot;
      sRem        = A[31] ? (~magRem + 32'd1) : magRem;
      longResult  = 64'd0;
      case (md_op)
         MD_MULT:  longResult = mulSigned;
         MD_MULTU: longResult = mulUnsigned;
         MD_DIV:   longResult = {sRem, sQuot};
         MD_DIVU:  longResult = {uRem, uQuot};
         default:  longResult = 64'd0;
      endcase
   end

   // State register. Reset wins over a simultaneous start and also aborts a
   // running operation, dropping its pending result so nothing commits later.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= MD_IDLE;
         count_q     <= '0;
         pend_q      <= 64'd0;
         pendValid_q <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         pend_q      <= pend_d;
         pendValid_q <= pendValid_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   // Next-state logic. In IDLE a long op latches its result and loads the
   // countdown; mthi/mtlo write straight through in one cycle. In RUN the
   // start input is deliberately ignored: the stall should make that case
   // impossible, and ignoring it keeps the in-flight op intact if it happens.
   // The commit on count==1 makes busy last exactly the loaded number of
   // cycles. A divide by zero still runs its full time but never commits.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      pend_d      = pend_q;
      pendValid_d = pendValid_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               if (isLongOp(md_op)) begin
                  pend_d      = longResult;
                  pendValid_d = !(isDivOp && divByZero);
                  count_d     = isDivOp ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
                  state_d     = MD_RUN;
               end else if (md_op == MD_MTHI) begin
                  hi_d = A;
               end else if (md_op == MD_MTLO) begin
                  lo_d = A;
               end
            end
         end
         MD_RUN: begin
            count_d = count_q - MD_CNT_W'(1);
            if (count_q == MD_CNT_W'(1)) begin
               if (pendValid_q) begin
                  hi_d = pend_q[63:32];
                  lo_d = pend_q[31:0];
               end
               pendValid_d = 1'b0;
               state_d     = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // Outputs. HI/LO are plain register outputs with no bypass, so any
   // mfhi/mflo held back by stall_md reads the committed value.
   always_comb begin
      busy     = (state_q == MD_RUN);
      stall_md = md_use_D & (start | busy);
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched
// Directed bench for md_sched. Stimulus tasks push the expected HI/LO/busy/
// stall_md values for each future cycle into a scoreboard queue; a monitor on
// the falling edge pops every entry due in the current cycle and compares.
module tb_md_sched;
   import md_sched_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        md_use_D;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        busy;
   logic        stall_md;

   typedef struct {
      int          due;
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        busy;
      logic        stall;
   } expT;

   expT sbQ[$];
   int  cyc = 0;
   int  compared = 0;
   int  mismatched = 0;

   md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .A        (A),
      .B        (B),
      .md_use_D (md_use_D),
      .HI       (HI),
      .LO       (LO),
      .busy     (busy),
      .stall_md (stall_md)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index shared by stimulus and monitor to schedule expectations
   always @(posedge clk) cyc <= cyc + 1;

   task automatic applyStimulus(input logic st, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic use_d);
      start    = st;
      md_op    = op;
      A        = a;
      B        = b;
      md_use_D = use_d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input int due, input string name,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic bsy, input logic stl);
      expT e;
      e.due   = due;
      e.name  = name;
      e.hi    = hi;
      e.lo    = lo;
      e.busy  = bsy;
      e.stall = stl;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input expT e);
      compared++;
      if (HI !== e.hi || LO !== e.lo || busy !== e.busy || stall_md !== e.stall) begin
         mismatched++;
         $display("[TB] FAIL %s: got HI=%h LO=%h busy=%b stall_md=%b, expected HI=%h LO=%h busy=%b stall_md=%b",
                  e.name, HI, LO, busy, stall_md, e.hi, e.lo, e.busy, e.stall);
      end
   endtask

   // Monitor: compare every scoreboard entry scheduled for this cycle
   always @(negedge clk) begin
      for (int i = sbQ.size() - 1; i >= 0; i--) begin
         if (sbQ[i].due == cyc) begin
            checkOutput(sbQ[i]);
            sbQ.delete(i);
         end
      end
   end

   // Issue one op and schedule its whole visible timeline: n busy cycles,
   // then the committed HI/LO one cycle after the last busy cycle.
   task automatic doOp(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input int n,
                       input logic [31:0] hiB, input logic [31:0] loB,
                       input logic [31:0] hiA, input logic [31:0] loA);
      int t;
      step();
      t = cyc;
      applyStimulus(1'b1, op, a, b, use_d);
      pushExp(t, $sformatf("%s@issue", name), hiB, loB, 1'b0, use_d);
      for (int i = 1; i <= n; i++)
         pushExp(t + i, $sformatf("%s@busy%0d", name, i), hiB, loB, 1'b1, use_d);
      pushExp(t + n + 1, $sformatf("%s@done", name), hiA, loA, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, use_d);
      repeat (n) step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int t;
      reset = 1'b1;
      applyStimulus(1'b1, MD_MULT, 32'd3, 32'd4, 1'b0);
      step();
      step();
      reset = 1'b0;
      applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
      pushExp(cyc, "reset", 32'd0, 32'd0, 1'b0, 1'b0);
      pushExp(cyc + 1, "resetWinsStart", 32'd0, 32'd0, 1'b0, 1'b0);
      step();

      doOp("mult",   MD_MULT,  32'hFFFFFFFF, 32'h2, 1'b1, 5,
           32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE);
      doOp("multu",  MD_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0, 5,
           32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE);
      doOp("divNeg", MD_DIV,   32'hFFFFFFF9, 32'h2, 1'b0, 10,
           32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);
      doOp("mthi",   MD_MTHI,  32'h11, 32'h0, 1'b1, 0,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'h11, 32'hFFFFFFFD);
      doOp("mtlo",   MD_MTLO,  32'h22, 32'h0, 1'b0, 0,
           32'h11, 32'hFFFFFFFD, 32'h11, 32'h22);
      doOp("divuZero", MD_DIVU, 32'h7, 32'h0, 1'b0, 10,
           32'h11, 32'h22, 32'h11, 32'h22);
      doOp("divNegB", MD_DIV,  32'h7, 32'hFFFFFFFE, 1'b0, 10,
           32'h11, 32'h22, 32'h1, 32'hFFFFFFFD);
      doOp("divu",   MD_DIVU,  32'hFFFFFFF9, 32'h2, 1'b0, 10,
           32'h1, 32'hFFFFFFFD, 32'h1, 32'h7FFFFFFC);
      doOp("mthi2",  MD_MTHI,  32'h12345678, 32'h0, 1'b0, 0,
           32'h1, 32'h7FFFFFFC, 32'h12345678, 32'h7FFFFFFC);
      doOp("multMin", MD_MULT, 32'h80000000, 32'h80000000, 1'b0, 5,
           32'h12345678, 32'h7FFFFFFC, 32'h40000000, 32'h0);
      doOp("opNone", MD_NONE,  32'hAAAA5555, 32'h1, 1'b1, 0,
           32'h40000000, 32'h0, 32'h40000000, 32'h0);
      doOp("opUndef", 3'd7,    32'hAAAA5555, 32'h1, 1'b0, 0,
           32'h40000000, 32'h0, 32'h40000000, 32'h0);

      // An mtlo arriving while a multiply runs must be ignored
      step();
      t = cyc;
      applyStimulus(1'b1, MD_MULT, 32'h3, 32'h5, 1'b0);
      pushExp(t, "ignoreStart@issue", 32'h40000000, 32'h0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++)
         pushExp(t + i, $sformatf("ignoreStart@busy%0d", i), 32'h40000000, 32'h0, 1'b1, 1'b0);
      pushExp(t + 6, "ignoreStart@done", 32'h0, 32'hF, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
      step();
      applyStimulus(1'b1, MD_MTLO, 32'hDEAD, 32'h0, 1'b0);
      step();
      applyStimulus(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
      repeat (3) step();
      @(negedge clk);
      #1;

      // Reset in the middle of a divide aborts it with no late commit
      step();
      t = cyc;
      applyStimulus(1'b1, MD_DIV, 32'd100, 32'd3, 1'b1);
      pushExp(t, "abort@issue", 32'h0, 32'hF, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++)
         pushExp(t + i, $sformatf("abort@busy%0d", i), 32'h0, 32'hF, 1'b1, 1'b1);
      pushExp(t + 5, "abort@afterReset", 32'h0, 32'h0, 1'b0, 1'b1);
      for (int i = 6; i <= 12; i++)
         pushExp(t + i, $sformatf("abort@quiet%0d", i), 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, MD_NONE, 32'h0, 32'h0, 1'b1);
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      applyStimulus(1'b1, MD_NONE, 32'h0, 32'h0, 1'b1);
      step();
      applyStimulus(1'b0, MD_NONE, 32'h0, 32'h0, 1'b1);
      repeat (6) step();
      @(negedge clk);
      #1;

      repeat (3) step();
      while (sbQ.size() > 0) begin
         expT e;
         e = sbQ.pop_front();
         compared++;
         mismatched++;
         $display("[TB] FAIL %s: never compared, due cycle %0d, now cycle %0d", e.name, e.due, cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
